// File: rtl/load_hazard_scoreboard_pkg.sv
// Shared constants and the pending-load slot type used by the load-use hazard unit.
package hazard_pkg;

    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 31;

    localparam int SRC_RN = 0;
    localparam int SRC_RM = 1;
    localparam int SRC_RT = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
    } pend_slot_t;

endpackage

// File: rtl/load_hazard_scoreboard_if.sv
// Bundle between the ID-stage pipeline control and the load-use hazard unit.
interface load_hazard_scoreboard_if #(
    parameter int NUM_SRC = 3,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
);
    logic                      ex_mem_read;
    logic [REG_AW-1:0]         ex_dest;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      flush;
    logic                      hold;
    logic                      pc_write;
    logic                      ifid_write;
    logic                      ctrl_bubble;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output ex_mem_read, ex_dest, id_valid, id_src, id_src_used, flush, hold,
        input  pc_write, ifid_write, ctrl_bubble, stall_count
    );

    modport slave (
        input  ex_mem_read, ex_dest, id_valid, id_src, id_src_used, flush, hold,
        output pc_write, ifid_write, ctrl_bubble, stall_count
    );
endinterface

// File: rtl/load_hazard_scoreboard_shreg.sv
// Age pipeline of loads that have left EX but whose data is not yet forwardable.
module load_pending_shreg
    import hazard_pkg::*;
#(
    parameter int  DEPTH = 0,
    localparam int W     = (DEPTH > 0) ? DEPTH : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold_i,
    input  pend_slot_t slot_i,
    output pend_slot_t slot_o [W]
);

    if (DEPTH > 0) begin : g_shreg
        pend_slot_t slot_q [DEPTH];
        pend_slot_t slot_d [DEPTH];

        always_comb begin
            for (int k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
            if (!hold_i) begin
                slot_d[0] = slot_i;
                for (int k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (reset) slot_q[k] <= '0;
                else       slot_q[k] <= slot_d[k];
            end
        end

        assign slot_o = slot_q;
    end else begin : g_empty
        // Single-cycle latency: the EX slot alone covers the hazard window.
        logic unused_in;
        assign unused_in = ^{slot_i, hold_i, clk, reset};
        assign slot_o[0] = '0;
    end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit: stalls ID while any source is owed by an in-flight load.
module load_hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int NUM_SRC  = 3,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    load_hazard_scoreboard_if.slave  bus
);
    import hazard_pkg::*;

    localparam logic [REG_AW-1:0] ZR  = REG_AW'(ZERO_REG);
    localparam int                SHW = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

    pend_slot_t             slot [LOAD_LAT];
    pend_slot_t             shreg_slot [SHW];
    logic [NUM_SRC*LOAD_LAT-1:0] hit;
    logic                   hazard;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign slot[0] = {bus.ex_mem_read && (bus.ex_dest != ZR), bus.ex_dest};

    load_pending_shreg #(.DEPTH(LOAD_LAT - 1)) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .hold_i (bus.hold),
        .slot_i (slot[0]),
        .slot_o (shreg_slot)
    );

    if (LOAD_LAT > 1) begin : g_age
        for (genvar k = 1; k < LOAD_LAT; k++) begin : g_slot
            assign slot[k] = shreg_slot[k-1];
        end
    end else begin : g_no_age
        logic unused_shreg;
        assign unused_shreg = ^shreg_slot[0];
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_AW-1:0] src;
        assign src = bus.id_src[s*REG_AW +: REG_AW];
        for (genvar k = 0; k < LOAD_LAT; k++) begin : g_cmp
            assign hit[s*LOAD_LAT + k] = bus.id_src_used[s] && (src != ZR) &&
                                         slot[k].valid && (slot[k].dest == src);
        end
    end

    // OR-reduce so duplicate matches collapse into a single stall.
    assign hazard = bus.id_valid && !bus.flush && (|hit);

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !bus.hold && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.ctrl_bubble = 1'b0;
        if (!reset && hazard) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.ctrl_bubble = 1'b1;
        end
    end

    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench: four hazard units (latency 1/2/3 and a 4-bit counter) on shared stimulus.
module tb_load_hazard_scoreboard;
    import hazard_pkg::*;

    localparam logic [2:0] STALL = 3'b001;   // {pc_write, ifid_write, ctrl_bubble}
    localparam logic [2:0] FREE  = 3'b110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    load_hazard_scoreboard_if #(.CNT_W(32)) if1 ();
    load_hazard_scoreboard_if #(.CNT_W(32)) if2 ();
    load_hazard_scoreboard_if #(.CNT_W(32)) if3 ();
    load_hazard_scoreboard_if #(.CNT_W(4))  ifs ();

    load_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(32)) u_l1 (.clk(clk), .reset(reset), .bus(if1));
    load_hazard_scoreboard #(.LOAD_LAT(2), .CNT_W(32)) u_l2 (.clk(clk), .reset(reset), .bus(if2));
    load_hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(32)) u_l3 (.clk(clk), .reset(reset), .bus(if3));
    load_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(4))  u_s  (.clk(clk), .reset(reset), .bus(ifs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic mr, input logic [4:0] dst,
                         input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rt, input logic [2:0] used,
                         input logic fl, input logic hd);
        @(negedge clk);
        reset = rs;
        if1.ex_mem_read = mr; if1.ex_dest = dst; if1.id_valid = v; if1.id_src = {rt, rm, rn};
        if1.id_src_used = used; if1.flush = fl; if1.hold = hd;
        if2.ex_mem_read = mr; if2.ex_dest = dst; if2.id_valid = v; if2.id_src = {rt, rm, rn};
        if2.id_src_used = used; if2.flush = fl; if2.hold = hd;
        if3.ex_mem_read = mr; if3.ex_dest = dst; if3.id_valid = v; if3.id_src = {rt, rm, rn};
        if3.id_src_used = used; if3.flush = fl; if3.hold = hd;
        ifs.ex_mem_read = mr; ifs.ex_dest = dst; ifs.id_valid = v; ifs.id_src = {rt, rm, rn};
        ifs.id_src_used = used; ifs.flush = fl; ifs.hold = hd;
        #1;
    endtask

    task automatic pulse_reset();
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset forces release even with a live hazard on the inputs
        drive(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("rst_force_l1", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, FREE);
        chk("rst_force_l3", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        pulse_reset();
        chk("rst_cnt_l1", if1.stall_count, 0);
        chk("rst_cnt_s", {28'd0, ifs.stall_count}, 0);

        // LOAD_LAT=1, Rn dependency
        drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("l1_stall", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, STALL);
        chk("l1_cnt0", if1.stall_count, 0);
        drive(1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("l1_release", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, FREE);
        chk("l1_cnt1", if1.stall_count, 1);

        // LOAD_LAT=3 back-to-back: three stalls
        pulse_reset();
        drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_b2b_s1", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_b2b_s2", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_b2b_s3", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_b2b_rel", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        chk("l3_b2b_cnt", if3.stall_count, 3);

        // LOAD_LAT=3 at distance 1: two stalls
        pulse_reset();
        drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("l3_d1_unrel", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_d1_s1", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_d1_s2", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("l3_d1_rel", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        chk("l3_d1_cnt", if3.stall_count, 2);

        // Duplicate source match counts once
        pulse_reset();
        drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 5'd0, 3'b011, 1'b0, 1'b0);
        chk("dup_stall", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, STALL);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        chk("dup_cnt_l1", if1.stall_count, 1);
        chk("dup_cnt_l3", if3.stall_count, 1);

        // Zero register and unused field
        pulse_reset();
        drive(1'b0, 1'b1, 5'd31, 1'b1, 5'd31, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("xzr_l1", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, FREE);
        chk("xzr_l3", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        drive(1'b0, 1'b1, 5'd4, 1'b1, 5'd9, 5'd4, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("unused_rm", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, FREE);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        chk("xzr_cnt_l3", if3.stall_count, 0);

        // Flush beats hazard
        pulse_reset();
        drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0);
        chk("flush_out", {29'd0, if1.pc_write, if1.ifid_write, if1.ctrl_bubble}, FREE);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        chk("flush_cnt", if1.stall_count, 0);

        // LOAD_LAT=2 with hold mid-stall
        pulse_reset();
        drive(1'b0, 1'b1, 5'd6, 1'b1, 5'd6, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("hold_s1", {29'd0, if2.pc_write, if2.ifid_write, if2.ctrl_bubble}, STALL);
        chk("hold_cnt0", if2.stall_count, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 5'd6, 1'b1, 5'd6, 5'd0, 5'd0, 3'b001, 1'b0, 1'b1);
            chk("hold_stall", {29'd0, if2.pc_write, if2.ifid_write, if2.ctrl_bubble}, STALL);
            chk("hold_cnt_frozen", if2.stall_count, 1);
        end
        drive(1'b0, 1'b0, 5'd6, 1'b1, 5'd6, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("hold_after", {29'd0, if2.pc_write, if2.ifid_write, if2.ctrl_bubble}, STALL);
        chk("hold_after_cnt", if2.stall_count, 1);
        drive(1'b0, 1'b0, 5'd6, 1'b1, 5'd6, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("hold_rel", {29'd0, if2.pc_write, if2.ifid_write, if2.ctrl_bubble}, FREE);
        chk("hold_rel_cnt", if2.stall_count, 2);

        // LOAD_LAT=3 reset during second stall cycle
        pulse_reset();
        drive(1'b0, 1'b1, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("rstmid_s1", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, STALL);
        drive(1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("rstmid_forced", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        drive(1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 5'd0, 3'b010, 1'b0, 1'b0);
        chk("rstmid_after", {29'd0, if3.pc_write, if3.ifid_write, if3.ctrl_bubble}, FREE);
        chk("rstmid_cnt", if3.stall_count, 0);

        // 4-bit counter saturation over 20 hazard cycles
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
            chk("sat_stall", {29'd0, ifs.pc_write, ifs.ifid_write, ifs.ctrl_bubble}, STALL);
            chk("sat_cnt", {28'd0, ifs.stall_count}, (i < 15) ? i : 15);
        end
        drive(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        chk("sat_hold15", {28'd0, ifs.stall_count}, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
